// File: rtl/mem_access_unit.sv
// Memory stage of the RV32I pipeline: issues loads/stores over a req/gnt/rvalid
// data-memory port and produces the registered MEM/WB result.
module mem_access_unit #(
  parameter int NB_WORD     = 32,
  parameter int NB_REG_ADDR = 5
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [NB_WORD-1:0]     i_alu_result,
  input  logic [NB_WORD-1:0]     i_store_data,
  input  logic                   i_mem_read,
  input  logic                   i_mem_write,
  input  logic [2:0]             i_funct3,
  input  logic [NB_REG_ADDR-1:0] i_rd,
  input  logic                   i_reg_write,
  output logic                   o_stall,
  output logic [NB_WORD-1:0]     o_ex_mem_alu_res,
  output logic                   o_dmem_req,
  output logic                   o_dmem_we,
  output logic [NB_WORD-1:0]     o_dmem_addr,
  output logic [3:0]             o_dmem_be,
  output logic [NB_WORD-1:0]     o_dmem_wdata,
  input  logic                   i_dmem_gnt,
  input  logic                   i_dmem_rvalid,
  input  logic [NB_WORD-1:0]     i_dmem_rdata,
  output logic                   o_wb_valid,
  output logic [NB_WORD-1:0]     o_wb_result,
  output logic [NB_REG_ADDR-1:0] o_wb_rd,
  output logic                   o_wb_reg_write,
  output logic                   o_misaligned
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NB_WORD-1:0]     addr_q;
  logic [NB_WORD-1:0]     data_q;
  logic [2:0]             funct3_q;
  logic [NB_REG_ADDR-1:0] rd_q;
  logic                   reg_write_q;
  logic                   store_q;

  logic                   is_mem;
  logic                   misaligned;
  logic                   accept;
  logic                   wb_valid_d;
  logic [NB_WORD-1:0]     wb_result_d;
  logic [NB_REG_ADDR-1:0] wb_rd_d;
  logic                   wb_reg_write_d;
  logic                   misaligned_d;

  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [NB_WORD-1:0]     ld_value;
  logic [3:0]             st_be;
  logic [NB_WORD-1:0]     st_wdata;

  assign is_mem = i_mem_read | i_mem_write;

  // Byte accesses are never misaligned; funct3 size 11 is treated as a word.
  always_comb begin
    misaligned = 1'b0;
    case (i_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = i_alu_result[0];
      default: misaligned = (i_alu_result[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    ld_byte = i_dmem_rdata[7:0];
    case (addr_q[1:0])
      2'b00: ld_byte = i_dmem_rdata[7:0];
      2'b01: ld_byte = i_dmem_rdata[15:8];
      2'b10: ld_byte = i_dmem_rdata[23:16];
      2'b11: ld_byte = i_dmem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_value = {{(NB_WORD-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_value = {{(NB_WORD-8){1'b0}}, ld_byte};
      3'b001:  ld_value = {{(NB_WORD-16){ld_half[15]}}, ld_half};
      3'b101:  ld_value = {{(NB_WORD-16){1'b0}}, ld_half};
      default: ld_value = i_dmem_rdata;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{data_q[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << addr_q[1:0];
        st_wdata = {2{data_q[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = data_q;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, the write-back value for the coming edge, and the memory port.
  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    wb_valid_d     = 1'b0;
    wb_result_d    = '0;
    wb_rd_d        = '0;
    wb_reg_write_d = 1'b0;
    misaligned_d   = 1'b0;
    o_stall        = 1'b0;
    o_dmem_req     = 1'b0;
    o_dmem_we      = 1'b0;
    o_dmem_addr    = '0;
    o_dmem_be      = 4'b0000;
    o_dmem_wdata   = '0;

    case (state)
      IDLE: begin
        if (i_valid) begin
          if (is_mem && misaligned) begin
            wb_valid_d   = 1'b1;
            wb_result_d  = i_alu_result;
            wb_rd_d      = i_rd;
            misaligned_d = 1'b1;
          end else if (is_mem) begin
            accept     = 1'b1;
            o_stall    = 1'b1;
            state_next = REQ;
          end else begin
            wb_valid_d     = 1'b1;
            wb_result_d    = i_alu_result;
            wb_rd_d        = i_rd;
            wb_reg_write_d = i_reg_write && (i_rd != '0);
          end
        end
      end

      REQ: begin
        o_stall      = 1'b1;
        o_dmem_req   = 1'b1;
        o_dmem_we    = store_q;
        o_dmem_addr  = {addr_q[NB_WORD-1:2], 2'b00};
        o_dmem_be    = store_q ? st_be : 4'b1111;
        o_dmem_wdata = store_q ? st_wdata : '0;
        if (i_dmem_gnt) begin
          if (store_q) begin
            state_next  = IDLE;
            wb_valid_d  = 1'b1;
            wb_result_d = addr_q;
            wb_rd_d     = rd_q;
          end else if (i_dmem_rvalid) begin
            state_next     = IDLE;
            wb_valid_d     = 1'b1;
            wb_result_d    = ld_value;
            wb_rd_d        = rd_q;
            wb_reg_write_d = reg_write_q && (rd_q != '0);
          end else begin
            state_next = WAIT_R;
          end
        end
      end

      WAIT_R: begin
        o_stall = 1'b1;
        if (i_dmem_rvalid) begin
          state_next     = IDLE;
          wb_valid_d     = 1'b1;
          wb_result_d    = ld_value;
          wb_rd_d        = rd_q;
          wb_reg_write_d = reg_write_q && (rd_q != '0);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Request context is captured once so the port stays stable until granted.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      addr_q           <= '0;
      data_q           <= '0;
      funct3_q         <= '0;
      rd_q             <= '0;
      reg_write_q      <= 1'b0;
      store_q          <= 1'b0;
      o_ex_mem_alu_res <= '0;
      o_wb_valid       <= 1'b0;
      o_wb_result      <= '0;
      o_wb_rd          <= '0;
      o_wb_reg_write   <= 1'b0;
      o_misaligned     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q      <= i_alu_result;
        data_q      <= i_store_data;
        funct3_q    <= i_funct3;
        rd_q        <= i_rd;
        reg_write_q <= i_reg_write;
        store_q     <= i_mem_write;
      end
      if (state == IDLE && i_valid) begin
        o_ex_mem_alu_res <= i_alu_result;
      end
      o_wb_valid     <= wb_valid_d;
      o_wb_result    <= wb_result_d;
      o_wb_rd        <= wb_rd_d;
      o_wb_reg_write <= wb_reg_write_d;
      o_misaligned   <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU pass-through, loads, stores,
// misaligned access and reset during an outstanding load.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        reg_write;
  logic        stall;
  logic [31:0] ex_mem_alu_res;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        misaligned;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mem_access_unit dut (
    .i_clock(clock), .i_reset(reset), .i_valid(valid),
    .i_alu_result(alu_result), .i_store_data(store_data),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .i_funct3(funct3),
    .i_rd(rd), .i_reg_write(reg_write), .o_stall(stall),
    .o_ex_mem_alu_res(ex_mem_alu_res), .o_dmem_req(dmem_req),
    .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_be(dmem_be),
    .o_dmem_wdata(dmem_wdata), .i_dmem_gnt(dmem_gnt),
    .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_wb_valid(wb_valid), .o_wb_result(wb_result), .o_wb_rd(wb_rd),
    .o_wb_reg_write(wb_reg_write), .o_misaligned(misaligned)
  );

  task automatic applyStimulus(input logic v, input logic [31:0] alu,
                               input logic [31:0] sdata, input logic rdEn,
                               input logic wrEn, input logic [2:0] f3,
                               input logic [4:0] dest, input logic rw);
    valid      = v;
    alu_result = alu;
    store_data = sdata;
    mem_read   = rdEn;
    mem_write  = wrEn;
    funct3     = f3;
    rd         = dest;
    reg_write  = rw;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = 32'h0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("reset_wb_valid", {31'b0, wb_valid}, 32'h0);
    checkOutput("reset_req", {31'b0, dmem_req}, 32'h0);
    checkOutput("reset_stall", {31'b0, stall}, 32'h0);
    checkOutput("reset_exmem", ex_mem_alu_res, 32'h0);

    // ALU pass-through
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0042, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1);
    #1 checkOutput("alu_stall", {31'b0, stall}, 32'h0);
    nextCycle();
    checkOutput("alu_wb_valid", {31'b0, wb_valid}, 32'h1);
    checkOutput("alu_result", wb_result, 32'h0000_0042);
    checkOutput("alu_rd", {27'b0, wb_rd}, 32'd5);
    checkOutput("alu_reg_write", {31'b0, wb_reg_write}, 32'h1);
    checkOutput("alu_exmem", ex_mem_alu_res, 32'h0000_0042);
    applyStimulus(1'b1, 32'h0000_1111, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b1);
    nextCycle();
    checkOutput("x0_wb_valid", {31'b0, wb_valid}, 32'h1);
    checkOutput("x0_reg_write", {31'b0, wb_reg_write}, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    nextCycle();
    checkOutput("idle_wb_valid", {31'b0, wb_valid}, 32'h0);
    checkOutput("idle_exmem_hold", ex_mem_alu_res, 32'h0000_1111);

    // LB at 0x103, gnt after two REQ cycles, rvalid one cycle later
    applyStimulus(1'b1, 32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'b000, 5'd7, 1'b1);
    #1 checkOutput("lb_stall_idle", {31'b0, stall}, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    #1;
    checkOutput("lb_req1", {31'b0, dmem_req}, 32'h1);
    checkOutput("lb_addr1", dmem_addr, 32'h0000_0100);
    checkOutput("lb_we", {31'b0, dmem_we}, 32'h0);
    checkOutput("lb_stall1", {31'b0, stall}, 32'h1);
    checkOutput("lb_wb_valid0", {31'b0, wb_valid}, 32'h0);
    nextCycle();
    checkOutput("lb_req2", {31'b0, dmem_req}, 32'h1);
    checkOutput("lb_addr2", dmem_addr, 32'h0000_0100);
    dmem_gnt = 1'b1;
    nextCycle();
    dmem_gnt = 1'b0;
    #1;
    checkOutput("lb_wait_req", {31'b0, dmem_req}, 32'h0);
    checkOutput("lb_wait_stall", {31'b0, stall}, 32'h1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80FF_1234;
    nextCycle();
    dmem_rvalid = 1'b0;
    #1;
    checkOutput("lb_wb_valid", {31'b0, wb_valid}, 32'h1);
    checkOutput("lb_result", wb_result, 32'hFFFF_FF80);
    checkOutput("lb_rd", {27'b0, wb_rd}, 32'd7);
    checkOutput("lb_stall_done", {31'b0, stall}, 32'h0);

    // LHU at 0x202 with gnt and rvalid in the same cycle
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0202, 32'h0, 1'b1, 1'b0, 3'b101, 5'd8, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBEEF_0000;
    nextCycle();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    checkOutput("lhu_wb_valid", {31'b0, wb_valid}, 32'h1);
    checkOutput("lhu_result", wb_result, 32'h0000_BEEF);

    // LH at 0x600 sign-extends the low halfword
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0600, 32'h0, 1'b1, 1'b0, 3'b001, 5'd9, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_8001;
    nextCycle();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    checkOutput("lh_result", wb_result, 32'hFFFF_8001);

    // SB at 0x301
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0301, 32'h0000_00AB, 1'b0, 1'b1, 3'b000, 5'd3, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    #1;
    checkOutput("sb_req", {31'b0, dmem_req}, 32'h1);
    checkOutput("sb_we", {31'b0, dmem_we}, 32'h1);
    checkOutput("sb_addr", dmem_addr, 32'h0000_0300);
    checkOutput("sb_be", {28'b0, dmem_be}, 32'h2);
    checkOutput("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    dmem_gnt = 1'b1;
    nextCycle();
    dmem_gnt = 1'b0;
    #1;
    checkOutput("sb_wb_valid", {31'b0, wb_valid}, 32'h1);
    checkOutput("sb_reg_write", {31'b0, wb_reg_write}, 32'h0);
    checkOutput("sb_no_wait_stall", {31'b0, stall}, 32'h0);

    // Misaligned LW at 0x402
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0402, 32'h0, 1'b1, 1'b0, 3'b010, 5'd9, 1'b1);
    #1;
    checkOutput("mis_req_idle", {31'b0, dmem_req}, 32'h0);
    checkOutput("mis_stall", {31'b0, stall}, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    #1;
    checkOutput("mis_pulse", {31'b0, misaligned}, 32'h1);
    checkOutput("mis_wb_valid", {31'b0, wb_valid}, 32'h1);
    checkOutput("mis_reg_write", {31'b0, wb_reg_write}, 32'h0);
    checkOutput("mis_req", {31'b0, dmem_req}, 32'h0);
    nextCycle();
    checkOutput("mis_pulse_end", {31'b0, misaligned}, 32'h0);
    checkOutput("mis_wb_end", {31'b0, wb_valid}, 32'h0);

    // Reset while waiting for read data, then a stale rvalid
    applyStimulus(1'b1, 32'h0000_0500, 32'h0, 1'b1, 1'b0, 3'b010, 5'd4, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    dmem_gnt = 1'b1;
    nextCycle();
    dmem_gnt = 1'b0;
    #1 checkOutput("rst_wait_stall", {31'b0, stall}, 32'h1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("rst_stall", {31'b0, stall}, 32'h0);
    checkOutput("rst_req", {31'b0, dmem_req}, 32'h0);
    checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
    checkOutput("rst_exmem", ex_mem_alu_res, 32'h0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    nextCycle();
    dmem_rvalid = 1'b0;
    #1;
    checkOutput("stale_wb_valid", {31'b0, wb_valid}, 32'h0);
    checkOutput("stale_stall", {31'b0, stall}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
